// File: rtl/int_cont_pri_pkg.sv
// Shared definitions for the priority interrupt controller: state encoding
// and a constant-foldable clog2 used to size the index and NOP counter.
package int_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRAIN = 2'b01,
    ST_JAL   = 2'b10,
    ST_ISR   = 2'b11
  } state_t;

  // Ceiling log2, floored at 1 so a width derived from it is never zero.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/int_cont_pri_if.sv
// Request/service bundle between the processor side (master) and the
// interrupt controller (slave).
interface int_cont_pri_if
  import int_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int NUM_W   = 16
);
  localparam int ID_W = clog2(NUM_SRC);

  logic               halt;
  logic [NUM_SRC-1:0] int_req;
  logic [NUM_SRC-1:0] int_mask;
  logic               int_ack;
  logic               safe_switch;
  logic               nop_detect;

  logic               int_rdy;
  logic               idle;
  logic               jal_req;
  logic               int_srv_req;
  logic [NUM_W-1:0]   int_srv_num;
  logic [ID_W-1:0]    int_srv_id;
  logic [NUM_SRC-1:0] int_pend;

  modport master (
    output halt, int_req, int_mask, int_ack, safe_switch, nop_detect,
    input  int_rdy, idle, jal_req, int_srv_req, int_srv_num, int_srv_id, int_pend
  );

  modport slave (
    input  halt, int_req, int_mask, int_ack, safe_switch, nop_detect,
    output int_rdy, idle, jal_req, int_srv_req, int_srv_num, int_srv_id, int_pend
  );

endinterface

// File: rtl/int_cont_pri_pri_enc.sv
// Lowest-index-first priority encoder: returns the index of the lowest set
// request bit and a flag telling whether any bit was set.
module int_pri_enc #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // below[i] is set when some request exists at an index lower than i.
  logic [N-1:0] below;
  logic [N-1:0] onehot;

  assign below[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < N; gi++) begin : g_below
      assign below[gi] = below[gi-1] | req[gi-1];
    end
  endgenerate

  assign onehot = req & ~below;
  assign valid  = |req;

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) begin
        idx = idx | IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/int_cont_pri.sv
// Priority interrupt controller: latches requests, picks the lowest unmasked
// pending source, drains the pipeline with NOPs, requests the JAL, then waits for ack.
module int_cont_pri
  import int_pkg::*;
#(
  parameter int               NUM_SRC  = 8,
  parameter int               NUM_W    = 16,
  parameter logic [NUM_W-1:0] VEC_BASE = '0,
  parameter int               NOP_WAIT = 4
) (
  input logic           clk,
  input logic           reset_b,
  int_cont_pri_if.slave bus
);

  localparam int ID_W  = clog2(NUM_SRC);
  localparam int CNT_W = clog2(NOP_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NOP_WAIT);

  state_t             state_reg,   state_next;
  logic [NUM_SRC-1:0] pend_reg,    pend_next;
  logic [CNT_W-1:0]   nop_cnt_reg, nop_cnt_next;
  logic [ID_W-1:0]    srv_id_reg,  srv_id_next;

  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] win_onehot;
  logic [NUM_SRC-1:0] pend_clr;
  logic [ID_W-1:0]    win_id;
  logic               win_valid;

  assign eligible = pend_reg & ~bus.int_mask;

  int_pri_enc #(
    .N     (NUM_SRC),
    .IDX_W (ID_W)
  ) u_pri_enc (
    .req   (eligible),
    .idx   (win_id),
    .valid (win_valid)
  );

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_onehot
      assign win_onehot[gi] = (win_id == ID_W'(gi));
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    nop_cnt_next = nop_cnt_reg;
    srv_id_next  = srv_id_reg;
    pend_clr     = '0;

    if (!bus.halt) begin
      case (state_reg)
        ST_IDLE: begin
          nop_cnt_next = '0;
          if (win_valid) begin
            state_next  = ST_DRAIN;
            srv_id_next = win_id;
            pend_clr    = win_onehot;
          end
        end
        ST_DRAIN: begin
          if (nop_cnt_reg == CNT_FULL && bus.safe_switch) begin
            state_next   = ST_JAL;
            nop_cnt_next = '0;
          end else if (bus.nop_detect && nop_cnt_reg != CNT_FULL) begin
            nop_cnt_next = nop_cnt_reg + CNT_W'(1);
          end
        end
        ST_JAL: begin
          state_next   = ST_ISR;
          nop_cnt_next = '0;
        end
        ST_ISR: begin
          nop_cnt_next = '0;
          if (bus.int_ack) begin
            state_next = ST_IDLE;
          end
        end
      endcase
    end

    // New requests are OR-ed in after the clear so a same-cycle re-request survives.
    pend_next = (pend_reg & ~pend_clr) | bus.int_req;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_reg   <= ST_IDLE;
      pend_reg    <= '0;
      nop_cnt_reg <= '0;
      srv_id_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      pend_reg    <= pend_next;
      nop_cnt_reg <= nop_cnt_next;
      srv_id_reg  <= srv_id_next;
    end
  end

  // Outputs decode the held state, so jal_req stays up through a halt.
  assign bus.int_rdy     = (state_reg == ST_IDLE);
  assign bus.idle        = (state_reg == ST_DRAIN);
  assign bus.jal_req     = (state_reg == ST_JAL);
  assign bus.int_srv_req = (state_reg != ST_IDLE);
  assign bus.int_srv_num = VEC_BASE + NUM_W'(srv_id_reg);
  assign bus.int_srv_id  = srv_id_reg;
  assign bus.int_pend    = pend_reg;

endmodule

// File: tb/tb_int_cont_pri.sv
// Directed table-driven bench for int_cont_pri (8 sources, VEC_BASE=0x0100,
// NOP_WAIT=4) plus hand-written asynchronous reset sequences.
module tb_int_cont_pri;

  localparam logic [15:0] VB = 16'h0100;

  typedef struct {
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;
    logic       safe;
    logic       nop;
    logic       halt;
    logic [1:0] st;
    logic [2:0] id;
    logic [7:0] pend;
  } vec_t;

  logic clk;
  logic reset_b;
  int   checks;
  int   errors;
  vec_t tbl[$];

  int_cont_pri_if #(.NUM_SRC(8), .NUM_W(16)) bus ();

  int_cont_pri #(
    .NUM_SRC  (8),
    .NUM_W    (16),
    .VEC_BASE (VB),
    .NOP_WAIT (4)
  ) dut (
    .clk     (clk),
    .reset_b (reset_b),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic [7:0] req, input logic [7:0] mask,
                     input logic ack, input logic safe, input logic nop, input logic halt,
                     input logic [1:0] st, input logic [2:0] id, input logic [7:0] pend);
    vec_t v;
    v.req = req; v.mask = mask; v.ack = ack; v.safe = safe; v.nop = nop; v.halt = halt;
    v.st = st; v.id = id; v.pend = pend;
    tbl.push_back(v);
  endtask

  // Expected output bundle {rdy, idle, jal, srv_req, num, id, pend}.
  function automatic logic [30:0] expv(input logic [1:0] st, input logic [2:0] id,
                                       input logic [7:0] pend);
    logic [15:0] num;
    num = VB + {13'd0, id};
    return {st == 2'd0, st == 2'd1, st == 2'd2, st != 2'd0, num, id, pend};
  endfunction

  function automatic logic [30:0] actv();
    return {bus.int_rdy, bus.idle, bus.jal_req, bus.int_srv_req,
            bus.int_srv_num, bus.int_srv_id, bus.int_pend};
  endfunction

  task automatic check(input string name, input logic [30:0] act, input logic [30:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got rdy/idle/jal/srv=%b num=%h id=%0d pend=%h, want rdy/idle/jal/srv=%b num=%h id=%0d pend=%h",
               name, act[30:27], act[26:11], act[10:8], act[7:0],
               exp[30:27], exp[26:11], exp[10:8], exp[7:0]);
    end else begin
      $display("ok   %s: rdy/idle/jal/srv=%b num=%h id=%0d pend=%h",
               name, act[30:27], act[26:11], act[10:8], act[7:0]);
    end
  endtask

  task automatic drive(input logic [7:0] req, input logic [7:0] mask, input logic ack,
                       input logic safe, input logic nop, input logic halt);
    bus.int_req     = req;
    bus.int_mask    = mask;
    bus.int_ack     = ack;
    bus.safe_switch = safe;
    bus.nop_detect  = nop;
    bus.halt        = halt;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    //   req    mask   ack  safe nop  halt   st  id  pend   (state after the edge)
    // single request on source 3
    add(8'h08, 8'h00, 0, 0, 0, 0, 2'd0, 3'd0, 8'h08);
    add(8'h00, 8'h00, 0, 0, 0, 0, 2'd1, 3'd3, 8'h00);
    add(8'h00, 8'h00, 0, 0, 1, 0, 2'd1, 3'd3, 8'h00);
    add(8'h00, 8'h00, 0, 0, 1, 0, 2'd1, 3'd3, 8'h00);
    add(8'h00, 8'h00, 0, 0, 1, 0, 2'd1, 3'd3, 8'h00);
    add(8'h00, 8'h00, 0, 1, 1, 0, 2'd1, 3'd3, 8'h00);
    add(8'h00, 8'h00, 0, 1, 0, 0, 2'd2, 3'd3, 8'h00);
    add(8'h00, 8'h00, 0, 0, 0, 0, 2'd3, 3'd3, 8'h00);
    add(8'h00, 8'h00, 0, 0, 0, 0, 2'd3, 3'd3, 8'h00);
    add(8'h00, 8'h00, 1, 0, 0, 0, 2'd0, 3'd3, 8'h00);
    // sources 1 and 3 together, source 1 masked
    add(8'h0A, 8'h02, 0, 0, 0, 0, 2'd0, 3'd3, 8'h0A);
    add(8'h00, 8'h02, 0, 0, 0, 0, 2'd1, 3'd3, 8'h02);
    add(8'h00, 8'h02, 0, 0, 1, 0, 2'd1, 3'd3, 8'h02);
    add(8'h00, 8'h02, 0, 0, 1, 0, 2'd1, 3'd3, 8'h02);
    add(8'h00, 8'h02, 0, 0, 1, 0, 2'd1, 3'd3, 8'h02);
    add(8'h00, 8'h02, 0, 0, 1, 0, 2'd1, 3'd3, 8'h02);
    add(8'h00, 8'h02, 0, 1, 0, 0, 2'd2, 3'd3, 8'h02);
    add(8'h00, 8'h00, 0, 0, 0, 0, 2'd3, 3'd3, 8'h02);
    add(8'h00, 8'h00, 1, 0, 0, 0, 2'd0, 3'd3, 8'h02);
    add(8'h00, 8'h00, 0, 0, 0, 0, 2'd1, 3'd1, 8'h00);
    // stray ack in DRAIN, then 6 NOPs without safe_switch (counter saturates)
    add(8'h00, 8'h00, 1, 0, 1, 0, 2'd1, 3'd1, 8'h00);
    add(8'h00, 8'h00, 0, 0, 1, 0, 2'd1, 3'd1, 8'h00);
    add(8'h00, 8'h00, 0, 0, 1, 0, 2'd1, 3'd1, 8'h00);
    add(8'h00, 8'h00, 0, 0, 1, 0, 2'd1, 3'd1, 8'h00);
    add(8'h00, 8'h00, 0, 0, 1, 0, 2'd1, 3'd1, 8'h00);
    add(8'h00, 8'h00, 0, 0, 1, 0, 2'd1, 3'd1, 8'h00);
    add(8'h00, 8'h00, 0, 1, 0, 0, 2'd2, 3'd1, 8'h00);
    // halt for 3 cycles in JAL
    add(8'h00, 8'h00, 0, 0, 0, 1, 2'd2, 3'd1, 8'h00);
    add(8'h00, 8'h00, 0, 0, 0, 1, 2'd2, 3'd1, 8'h00);
    add(8'h00, 8'h00, 0, 0, 0, 1, 2'd2, 3'd1, 8'h00);
    add(8'h00, 8'h00, 0, 0, 0, 0, 2'd3, 3'd1, 8'h00);
    add(8'h00, 8'h00, 1, 0, 0, 0, 2'd0, 3'd1, 8'h00);
    // re-request on the capture cycle, halted NOPs in DRAIN
    add(8'h01, 8'h00, 0, 0, 0, 0, 2'd0, 3'd1, 8'h01);
    add(8'h01, 8'h00, 0, 0, 0, 0, 2'd1, 3'd0, 8'h01);
    add(8'h00, 8'h00, 0, 0, 1, 1, 2'd1, 3'd0, 8'h01);
    add(8'h00, 8'h00, 1, 0, 1, 1, 2'd1, 3'd0, 8'h01);
    add(8'h00, 8'h00, 0, 0, 1, 0, 2'd1, 3'd0, 8'h01);
    add(8'h00, 8'h00, 0, 0, 1, 0, 2'd1, 3'd0, 8'h01);
    add(8'h00, 8'h00, 0, 1, 1, 0, 2'd1, 3'd0, 8'h01);
    add(8'h00, 8'h00, 0, 1, 1, 0, 2'd1, 3'd0, 8'h01);
    add(8'h00, 8'h00, 0, 1, 0, 0, 2'd2, 3'd0, 8'h01);
    add(8'h00, 8'h00, 0, 0, 0, 0, 2'd3, 3'd0, 8'h01);
    add(8'h00, 8'h00, 1, 0, 0, 0, 2'd0, 3'd0, 8'h01);
    add(8'h00, 8'h00, 0, 0, 0, 0, 2'd1, 3'd0, 8'h00);
    // request latched while halted; masking the in-service source changes nothing
    add(8'h04, 8'h00, 0, 0, 0, 1, 2'd1, 3'd0, 8'h04);
    add(8'h00, 8'h01, 0, 0, 0, 0, 2'd1, 3'd0, 8'h04);

    drive(8'h00, 8'h00, 0, 0, 0, 0);
    reset_b = 1'b0;
    #12;
    check("reset_async", actv(), expv(2'd0, 3'd0, 8'h00));
    reset_b = 1'b1;
    @(posedge clk);
    #1;
    check("reset_state", actv(), expv(2'd0, 3'd0, 8'h00));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].req, tbl[i].mask, tbl[i].ack, tbl[i].safe, tbl[i].nop, tbl[i].halt);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), actv(), expv(tbl[i].st, tbl[i].id, tbl[i].pend));
    end

    // Reset mid-service: source 3 pending while in DRAIN, reset away from the edge.
    drive(8'h08, 8'h00, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("pre_reset", actv(), expv(2'd1, 3'd0, 8'h0C));
    drive(8'h00, 8'h00, 0, 0, 1, 0);
    #2;
    reset_b = 1'b0;
    #1;
    check("reset_mid_service", actv(), expv(2'd0, 3'd0, 8'h00));
    @(posedge clk);
    #1;
    check("reset_held", actv(), expv(2'd0, 3'd0, 8'h00));
    #3;
    reset_b = 1'b1;

    // Request-to-DRAIN latency after reset release.
    @(posedge clk);
    #1;
    drive(8'h08, 8'h00, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("post_reset_pend", actv(), expv(2'd0, 3'd0, 8'h08));
    drive(8'h00, 8'h00, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("post_reset_drain", actv(), expv(2'd1, 3'd3, 8'h00));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
